// File: rtl/alu_ctrl_exec.sv
// ALU control decode with a registered execute stage and valid/ready handshakes on both sides.
// Define ALU_MUL_EN to build the iterative shift-add multiplier (aluop 11, funct 0000).
module alu_ctrl_exec #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       aluop,
    input  logic [3:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       operation,
    output logic             zero,
    output logic             illegal,
    output logic             busy
);
    localparam int SHAMT_W = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HOLD = 2'd2;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1010;
    localparam logic [3:0] OP_ILL  = 4'b1111;
`ifdef ALU_MUL_EN
    localparam logic [1:0] S_MUL   = 2'd1;
    localparam logic [3:0] OP_MUL  = 4'b1001;
    localparam logic [SHAMT_W-1:0] CNT_LAST = SHAMT_W'(WIDTH - 1);
`endif

    logic [1:0]         r_state;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_result;
    logic [3:0]         r_operation;
    logic               r_zero;
    logic               r_illegal;
    logic               r_busy;

    logic [3:0]         w_op;
    logic               w_illegal;
    logic [WIDTH-1:0]   w_alu_res;
    logic [SHAMT_W-1:0] w_shamt;

    assign w_shamt = b[SHAMT_W-1:0];

    // Decode aluop/funct into the operation code presented at accept
    always_comb begin
        w_op = OP_ILL;
        case (aluop)
            2'b00: w_op = OP_ADD;
            2'b01: w_op = OP_SUB;
            2'b10: begin
                case (funct)
                    4'b0000: w_op = OP_ADD;
                    4'b1000: w_op = OP_SUB;
                    4'b0111: w_op = OP_AND;
                    4'b0110: w_op = OP_OR;
                    4'b0100: w_op = OP_XOR;
                    4'b0001: w_op = OP_SLL;
                    4'b0101: w_op = OP_SRL;
                    4'b1101: w_op = OP_SRA;
                    4'b0010: w_op = OP_SLT;
                    4'b0011: w_op = OP_SLTU;
                    default: w_op = OP_ILL;
                endcase
            end
            2'b11: begin
`ifdef ALU_MUL_EN
                if (funct == 4'b0000) begin
                    w_op = OP_MUL;
                end else begin
                    w_op = OP_ILL;
                end
`else
                w_op = OP_ILL;
`endif
            end
            default: w_op = OP_ILL;
        endcase
        w_illegal = (w_op == OP_ILL);
    end

    // Single-cycle datapath; illegal and MUL codes yield zero here
    always_comb begin
        w_alu_res = {WIDTH{1'b0}};
        case (w_op)
            OP_ADD:  w_alu_res = a + b;
            OP_SUB:  w_alu_res = a - b;
            OP_AND:  w_alu_res = a & b;
            OP_OR:   w_alu_res = a | b;
            OP_XOR:  w_alu_res = a ^ b;
            OP_SLL:  w_alu_res = a << w_shamt;
            OP_SRL:  w_alu_res = a >> w_shamt;
            OP_SRA:  w_alu_res = $signed(a) >>> w_shamt;
            OP_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: w_alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            default: w_alu_res = {WIDTH{1'b0}};
        endcase
    end

`ifdef ALU_MUL_EN
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [WIDTH-1:0]   r_acc;
    logic [SHAMT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   w_acc_next;

    // Iteration i adds a<<i when multiplier bit i (shifted down to bit 0) is set
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : {WIDTH{1'b0}});

    // Multiplier operand, accumulator and iteration counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mcand  <= {WIDTH{1'b0}};
            r_mplier <= {WIDTH{1'b0}};
            r_acc    <= {WIDTH{1'b0}};
            r_cnt    <= {SHAMT_W{1'b0}};
        end else if ((r_state == S_IDLE) && in_valid && (w_op == OP_MUL)) begin
            r_mcand  <= a;
            r_mplier <= b;
            r_acc    <= {WIDTH{1'b0}};
            r_cnt    <= {SHAMT_W{1'b0}};
        end else if (r_state == S_MUL) begin
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_acc    <= w_acc_next;
            r_cnt    <= r_cnt + SHAMT_W'(1);
        end
    end
`endif

    // Control FSM and registered result/status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_result    <= {WIDTH{1'b0}};
            r_operation <= 4'b0000;
            r_zero      <= 1'b0;
            r_illegal   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
`ifdef ALU_MUL_EN
                        if (w_op == OP_MUL) begin
                            r_busy  <= 1'b1;
                            r_state <= S_MUL;
                        end else begin
                            r_result    <= w_alu_res;
                            r_operation <= w_op;
                            r_zero      <= (w_alu_res == {WIDTH{1'b0}});
                            r_illegal   <= w_illegal;
                            r_out_valid <= 1'b1;
                            r_state     <= S_HOLD;
                        end
`else
                        r_result    <= w_alu_res;
                        r_operation <= w_op;
                        r_zero      <= (w_alu_res == {WIDTH{1'b0}});
                        r_illegal   <= w_illegal;
                        r_out_valid <= 1'b1;
                        r_state     <= S_HOLD;
`endif
                    end
                end
`ifdef ALU_MUL_EN
                S_MUL: begin
                    if (r_cnt == CNT_LAST) begin
                        r_result    <= w_acc_next;
                        r_operation <= OP_MUL;
                        r_zero      <= (w_acc_next == {WIDTH{1'b0}});
                        r_illegal   <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_HOLD;
                    end
                end
`endif
                S_HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign operation = r_operation;
    assign zero      = r_zero;
    assign illegal   = r_illegal;
    assign busy      = r_busy;

endmodule

// File: tb/tb_alu_ctrl_exec.sv
// Randomized self-checking bench for alu_ctrl_exec (WIDTH=32) against a behavioural model.
// Multiplier scenarios are compiled in only when ALU_MUL_EN is defined.
module tb_alu_ctrl_exec;
    localparam int W = 32;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    aluop;
    logic [3:0]    funct;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic [3:0]    operation;
    logic          zero;
    logic          illegal;
    logic          busy;

    int n_total = 0;
    int n_bad   = 0;

    alu_ctrl_exec #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .aluop     (aluop),
        .funct     (funct),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .operation (operation),
        .zero      (zero),
        .illegal   (illegal),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Behavioural model: returns {operation, result}
    function automatic logic [35:0] ref_model(input logic [1:0] s, input logic [3:0] f,
                                              input logic [31:0] x, input logic [31:0] y);
        int unsigned sh;
        int          sx;
        int          sy;
        logic [63:0] prod;
        logic [31:0] fill;
        sh   = y % 32;
        sx   = x;
        sy   = y;
        fill = 32'hFFFF_FFFF;
        if (s == 2'd0) return {4'b0010, x + y};
        if (s == 2'd1) return {4'b0110, x - y};
        if (s == 2'd2) begin
            case (f)
                4'd0:  return {4'b0010, x + y};
                4'd8:  return {4'b0110, x - y};
                4'd7:  return {4'b0000, x & y};
                4'd6:  return {4'b0001, x | y};
                4'd4:  return {4'b0011, x ^ y};
                4'd1:  return {4'b0100, x << sh};
                4'd5:  return {4'b0101, x >> sh};
                4'd13: return {4'b0111, (x >> sh) | (x[31] ? ~(fill >> sh) : 32'd0)};
                4'd2:  return {4'b1000, (sx < sy) ? 32'd1 : 32'd0};
                4'd3:  return {4'b1010, (x < y) ? 32'd1 : 32'd0};
                default: return {4'b1111, 32'd0};
            endcase
        end
`ifdef ALU_MUL_EN
        if (f == 4'd0) begin
            prod = {32'd0, x} * {32'd0, y};
            return {4'b1001, prod[31:0]};
        end
`endif
        return {4'b1111, 32'd0};
    endfunction

    // One full transaction: accept, wait for result, optional stall, transfer
    task automatic do_op(input logic [1:0] s, input logic [3:0] f, input logic [31:0] x,
                         input logic [31:0] y, input logic [3:0] exp_op, input logic [31:0] exp_res,
                         input int stall, input bit hold_poke);
        int edges;
        int busy_cnt;
        int exp_edges;
        exp_edges = (exp_op == 4'b1001) ? 33 : 1;
        out_ready = 1'b0;
        chk_eq("in_ready_idle", in_ready, 1'b1);
        in_valid = 1'b1; aluop = s; funct = f; a = x; b = y;
        @(posedge clk); #1;
        in_valid = 1'b0;
        aluop = 2'($urandom); funct = 4'($urandom); a = $urandom; b = $urandom;
        edges = 1;
        busy_cnt = 0;
        while (!out_valid && edges < 100) begin
            if (busy) busy_cnt++;
            chk_eq("in_ready_mul", in_ready, 1'b0);
            if (edges == 5) begin
                in_valid = 1'b1; aluop = 2'b00;
            end
            if (edges == 8) in_valid = 1'b0;
            @(posedge clk); #1;
            edges++;
        end
        in_valid = 1'b0;
        chk_eq("out_valid", out_valid, 1'b1);
        chk_eq("latency", edges, exp_edges);
        chk_eq("busy_cycles", busy_cnt, (exp_op == 4'b1001) ? 32 : 0);
        chk_eq("busy_done", busy, 1'b0);
        chk_eq("result", result, exp_res);
        chk_eq("operation", operation, exp_op);
        chk_eq("zero", zero, exp_res == 32'd0);
        chk_eq("illegal", illegal, exp_op == 4'b1111);
        chk_eq("in_ready_hold", in_ready, 1'b0);
        for (int i = 0; i < stall; i++) begin
            if (hold_poke) begin
                in_valid = 1'b1; aluop = 2'b00; a = $urandom; b = $urandom;
            end
            @(posedge clk); #1;
            chk_eq("hold_valid", out_valid, 1'b1);
            chk_eq("hold_result", result, exp_res);
            chk_eq("hold_op", operation, exp_op);
            chk_eq("hold_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk_eq("xfer_valid", out_valid, 1'b0);
        chk_eq("xfer_in_ready", in_ready, 1'b1);
        chk_eq("xfer_result_kept", result, exp_res);
    endtask

    task automatic check_reset_state();
        chk_eq("rst_in_ready", in_ready, 1'b1);
        chk_eq("rst_out_valid", out_valid, 1'b0);
        chk_eq("rst_result", result, 32'd0);
        chk_eq("rst_operation", operation, 4'd0);
        chk_eq("rst_zero", zero, 1'b0);
        chk_eq("rst_illegal", illegal, 1'b0);
        chk_eq("rst_busy", busy, 1'b0);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    logic [3:0] legal_fn [10] = '{4'd0, 4'd8, 4'd7, 4'd6, 4'd4, 4'd1, 4'd5, 4'd13, 4'd2, 4'd3};

    initial begin
        logic [35:0] m;
        logic [1:0]  s;
        logic [3:0]  f;
        logic [31:0] x;
        logic [31:0] y;
        int          seen;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        aluop = 2'b00; funct = 4'b0000; a = 32'd0; b = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_reset_state();

        do_op(2'b10, 4'b0000, 32'd5, 32'd7, 4'b0010, 32'd12, 0, 1'b0);
        do_op(2'b01, 4'b0000, 32'd9, 32'd9, 4'b0110, 32'd0, 0, 1'b0);
        do_op(2'b10, 4'b1101, 32'h8000_0000, 32'd4, 4'b0111, 32'hF800_0000, 0, 1'b0);
        do_op(2'b10, 4'b0010, 32'hFFFF_FFFF, 32'd1, 4'b1000, 32'd1, 0, 1'b0);
        do_op(2'b10, 4'b0011, 32'hFFFF_FFFF, 32'd1, 4'b1010, 32'd0, 0, 1'b0);
        do_op(2'b10, 4'b1111, 32'd3, 32'd4, 4'b1111, 32'd0, 5, 1'b1);
        do_op(2'b00, 4'b1010, 32'hFFFF_FFFF, 32'd2, 4'b0010, 32'd1, 5, 1'b1);
`ifdef ALU_MUL_EN
        do_op(2'b11, 4'b0000, 32'h0001_0001, 32'h0003_0003, 4'b1001, 32'h0006_0003, 5, 1'b1);
`else
        do_op(2'b11, 4'b0000, 32'h0001_0001, 32'h0003_0003, 4'b1111, 32'd0, 2, 1'b0);
`endif

        for (int k = 0; k < 40; k++) begin
            s = 2'($urandom);
            f = ($urandom_range(0, 3) == 0) ? 4'($urandom) : legal_fn[$urandom_range(0, 9)];
            if (s == 2'b11 && $urandom_range(0, 1) == 1) f = 4'd0;
            case ($urandom_range(0, 5))
                0: begin x = 32'd0; y = $urandom; end
                1: begin x = 32'hFFFF_FFFF; y = $urandom; end
                2: begin x = 32'h8000_0000; y = $urandom_range(0, 40); end
                3: begin x = $urandom; y = x; end
                default: begin x = $urandom; y = $urandom; end
            endcase
            m = ref_model(s, f, x, y);
            do_op(s, f, x, y, m[35:32], m[31:0], $urandom_range(0, 3), 1'($urandom));
        end

        // Reset while a result is held: discarded, outputs return to reset values
        in_valid = 1'b1; aluop = 2'b00; a = 32'd1; b = 32'd1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk_eq("hold_before_rst", out_valid, 1'b1);
        pulse_reset();
        check_reset_state();

`ifdef ALU_MUL_EN
        // Reset in the middle of a multiply: no result may ever appear
        in_valid = 1'b1; aluop = 2'b11; funct = 4'b0000; a = 32'h0001_0001; b = 32'h0003_0003;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk_eq("busy_mid_mul", busy, 1'b1);
        pulse_reset();
        check_reset_state();
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk_eq("no_result_after_rst", seen, 0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
